stis4_r2_share_reg: RTL and testbench

Registered share stage directly downstream of the round-2 4-bit S-box threshold-implementation component functions. Captures the 1-bit outputs of all component functions (grouped as NSH output shares of 4 bits), optionally applies a sum-preserving ring refresh from an internal LFSR, and presents the shares to the next round through a valid/ready handshake with a one-entry skid buffer. This register is mandatory between TI stages: it stops glitch propagation and keeps the non-completeness property intact.

---
 rtl/stis4_pkg.sv | 35 +++
 rtl/stis4_lfsr16.sv | 30 +++
 rtl/stis4_r2_share_reg.sv | 103 ++++++++++
 tb/tb_stis4_r2_share_reg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stis4_pkg.sv
// Shared definitions for the 4-bit S-box threshold-implementation rounds:
// widths, LFSR constants, handshake stage encoding and the ring refresh.
package stis4_pkg;

  localparam int              SBOX_W    = 4;
  localparam int              LFSR_W    = 16;
  localparam int              MAX_SH    = LFSR_W / SBOX_W;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_RST  = 16'hACE1;

  // Stage occupancy, encoded as {skid_full, out_valid}; 2'b10 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  // share_j ^= m_j ^ m_((j+1) mod nsh). Every mask appears exactly twice,
  // so the XOR across all shares is preserved. Unused share slots stay 0.
  function automatic logic [LFSR_W-1:0] ring_refresh(input logic [LFSR_W-1:0] shares,
                                                    input logic [LFSR_W-1:0] masks,
                                                    input int                nsh);
    logic [LFSR_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_SH; j++) begin
      if (j < nsh)
        r[j*SBOX_W +: SBOX_W] = shares[j*SBOX_W +: SBOX_W]
                              ^ masks[j*SBOX_W +: SBOX_W]
                              ^ masks[((j + 1) % nsh)*SBOX_W +: SBOX_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/stis4_lfsr16.sv
// 16-bit Fibonacci LFSR (left shift, feedback into bit 0) with seed load.
// A zero seed would lock the register, so it is replaced by RST_VAL.
module stis4_lfsr16
  import stis4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = LFSR_RST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] state
);

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  // Load wins over advance; otherwise step only when asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RST_VAL;
    else if (load)
      state <= (seed == '0) ? RST_VAL : seed;
    else if (adv)
      state <= {state[LFSR_W-2:0], fb};
  end

endmodule

// File: rtl/stis4_r2_share_reg.sv
// Round-2 share register: captures the component-function outputs, applies an
// optional sum-preserving ring refresh and hands them on through a
// valid/ready interface with a one-entry skid. All outputs come from flops so
// no glitch crosses into the next TI stage.
module stis4_r2_share_reg
  import stis4_pkg::*;
#(
  parameter int                NSH      = 3,
  parameter logic [LFSR_W-1:0] LFSR_RST = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed,
  input  logic                  refresh_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSH*SBOX_W-1:0] in_shares,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NSH*SBOX_W-1:0] out_shares
);

  localparam int DW = NSH * SBOX_W;

  state_e          state, state_nxt;
  logic            skid_full;
  logic [DW-1:0]   skid_data;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] in_pad, mask, cap_full;
  logic [DW-1:0]   cap;
  logic            accept, present;
  logic            ld_out, ld_skid, sel_skid;

  assign skid_full = state[1];
  assign out_valid = state[0];
  assign in_ready  = !skid_full;
  assign accept    = in_valid && in_ready;
  assign present   = out_valid && out_ready;

  // Masks are taken from the pre-advance LFSR state of the accepting cycle.
  always_comb begin
    in_pad         = '0;
    in_pad[DW-1:0] = in_shares;
    mask           = refresh_en ? lfsr : '0;
    cap_full       = ring_refresh(in_pad, mask, NSH);
    cap            = cap_full[DW-1:0];
  end

  stis4_lfsr16 #(.RST_VAL(LFSR_RST)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .seed  (seed),
    .adv   (accept && refresh_en),
    .state (lfsr)
  );

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next occupancy and which data register loads from where.
  always_comb begin
    state_nxt = state;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    sel_skid  = 1'b0;
    case (state)
      ST_EMPTY: if (accept) begin
        state_nxt = ST_ONE;
        ld_out    = 1'b1;
      end
      ST_ONE: begin
        if (accept && present)      ld_out = 1'b1;
        else if (accept) begin
          state_nxt = ST_FULL;
          ld_skid   = 1'b1;
        end else if (present)       state_nxt = ST_EMPTY;
      end
      ST_FULL: if (present) begin
        state_nxt = ST_ONE;
        ld_out    = 1'b1;
        sel_skid  = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Data registers; refresh is already applied, so these are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shares <= '0;
      skid_data  <= '0;
    end else begin
      if (ld_out)  out_shares <= sel_skid ? skid_data : cap;
      if (ld_skid) skid_data  <= cap;
    end
  end

endmodule

// File: tb/tb_stis4_r2_share_reg.sv
// Bench for stis4_r2_share_reg (NSH = 3): scoreboard monitor plus
// per-scenario tasks with directed checks.
module tb_stis4_r2_share_reg;

  typedef struct {
    logic [11:0] exp;
    logic [3:0]  in_x;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        refresh_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_shares = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_shares;

  int total = 0;
  int bad   = 0;
  sb_t q[$];
  logic [15:0] m_lfsr = 16'hACE1;

  stis4_r2_share_reg #(.NSH(3), .LFSR_RST(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .refresh_en(refresh_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares), .out_valid(out_valid), .out_ready(out_ready),
    .out_shares(out_shares)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [11:0] ref_out(input logic [11:0] s, input logic [15:0] l);
    logic [3:0] m0, m1, m2;
    m0 = l[3:0]; m1 = l[7:4]; m2 = l[11:8];
    return {s[11:8] ^ m2 ^ m0, s[7:4] ^ m1 ^ m2, s[3:0] ^ m0 ^ m1};
  endfunction

  // Monitor: sample mid-cycle, pop on present, push on accept, track LFSR.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow got=%h want=<none>", out_shares);
        end else begin
          sb_t e;
          e = q.pop_front();
          if (out_shares !== e.exp) begin
            bad++;
            $display("FAIL sb_data got=%h want=%h", out_shares, e.exp);
          end
          total++;
          if ((out_shares[3:0] ^ out_shares[7:4] ^ out_shares[11:8]) !== e.in_x) begin
            bad++;
            $display("FAIL sb_xor got=%h want=%h",
                     out_shares[3:0] ^ out_shares[7:4] ^ out_shares[11:8], e.in_x);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_t n;
        n.exp  = refresh_en ? ref_out(in_shares, m_lfsr) : in_shares;
        n.in_x = in_shares[3:0] ^ in_shares[7:4] ^ in_shares[11:8];
        q.push_back(n);
        if (refresh_en) m_lfsr = lfsr_step(m_lfsr);
      end
      if (seed_load) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || q.size() != 0) && n < 50) begin tick(); n++; end
    total++;
    if (q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain left=%0d out_valid=%b want 0/0", q.size(), out_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_shares !== 12'h000) begin
      bad++;
      $display("FAIL reset got v=%b r=%b d=%h want 0 1 000", out_valid, in_ready, out_shares);
    end
    @(negedge clk); rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got r=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_pass();
    refresh_en = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_shares = 12'h5A3;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_shares !== 12'h5A3 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL pass got v=%b d=%h r=%b want 1 5a3 1", out_valid, out_shares, in_ready);
    end
    drain();
  endtask

  task automatic test_refresh();
    int sent = 0, cyc = 0;
    seed_load = 1'b1; seed = 16'h1234;
    tick();
    seed_load = 1'b0; refresh_en = 1'b1;
    while (sent < 1000 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_shares = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    total++;
    if (sent != 1000) begin
      bad++;
      $display("FAIL refresh_timeout sent=%0d want 1000", sent);
    end
    drain();
  endtask

  task automatic test_backpressure();
    refresh_en = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_shares = 12'h111;
    tick();
    in_shares = 12'h222;
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_shares !== 12'h111) begin
      bad++;
      $display("FAIL bp_full got r=%b v=%b d=%h want 0 1 111", in_ready, out_valid, out_shares);
    end
    tick();
    total++;
    if (out_shares !== 12'h111 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold got d=%h r=%b want 111 0", out_shares, in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_shares !== 12'h222 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_second got v=%b d=%h r=%b want 1 222 1", out_valid, out_shares, in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty got v=%b want 0", out_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    refresh_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_shares = 12'(i);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_shares !== 12'(i) || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b[%0d] got v=%b d=%h r=%b want 1 %h 1", i, out_valid, out_shares, in_ready, 12'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got v=%b want 0", out_valid);
    end
    drain();
  endtask

  // Zero seed loaded during an accept: that accept uses the old state, the
  // next one sees 16'hACE1 (masks 1,E,C -> input 000 becomes D2F).
  task automatic test_seed_load();
    refresh_en = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_shares = 12'h9C4;
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    in_shares = 12'h000;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_shares !== 12'hD2F) begin
      bad++;
      $display("FAIL seed_zero got v=%b d=%h want 1 d2f", out_valid, out_shares);
    end
    drain();
  endtask

  task automatic test_async_reset_full();
    refresh_en = 1'b1; out_ready = 1'b0;
    seed_load = 1'b1; seed = 16'h5555;
    tick();
    seed_load = 1'b0;
    in_valid = 1'b1; in_shares = 12'h3C3;
    tick();
    in_shares = 12'h7E1;
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL ar_full got r=%b v=%b want 0 1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_lfsr = 16'hACE1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_shares !== 12'h000) begin
      bad++;
      $display("FAIL ar_now got v=%b r=%b d=%h want 0 1 000", out_valid, in_ready, out_shares);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_shares = 12'h000;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_shares !== 12'hD2F) begin
      bad++;
      $display("FAIL ar_lfsr got v=%b d=%h want 1 d2f", out_valid, out_shares);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_refresh();
    test_backpressure();
    test_back_to_back();
    test_seed_load();
    test_async_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
